// File: rtl/rca_cmd_dispatch_pkg.sv
// Shared types and constants for the RCA command dispatch path.
package rca_cmd_dispatch_pkg;

    // Major opcode reserved for RCA custom instructions.
    localparam logic [6:0] RCA_OPCODE = 7'b0101011;

    // Width of the id field stored in each queued command.
    // The top-level ID_W must not exceed this value.
    localparam int RCA_ID_W_MAX = 8;

    // fn7 encodings: 0..1 are exec forms, 2..6 are config writes.
    typedef enum logic [6:0] {
        FN7_USE_FB      = 7'd0,
        FN7_USE_NFB     = 7'd1,
        FN7_CPU_REG     = 7'd2,
        FN7_GRID_MUX    = 7'd3,
        FN7_IO_MUX      = 7'd4,
        FN7_RESULT_MUX  = 7'd5,
        FN7_IO_INP_MAP  = 7'd6
    } rca_fn7_e;

    // Config-write kind as presented on the config port (fn7 - 2).
    typedef enum logic [2:0] {
        CFG_CPU_REG     = 3'd0,
        CFG_GRID_MUX    = 3'd1,
        CFG_IO_MUX      = 3'd2,
        CFG_RESULT_MUX  = 3'd3,
        CFG_IO_INP_MAP  = 3'd4
    } rca_cfg_kind_t;

    // One queued command; addr/data carry rs1/rs2 for config writes.
    typedef struct packed {
        logic                    is_cfg;
        logic [2:0]              rca_sel;
        rca_cfg_kind_t           kind;
        logic                    use_fb;
        logic [RCA_ID_W_MAX-1:0] id;
        logic [31:0]             addr;
        logic [31:0]             data;
    } rca_cmd_t;

    // Map a config fn7 (2..6) onto its kind encoding.
    function automatic rca_cfg_kind_t fn7_to_kind(input logic [6:0] fn7);
        logic [6:0] k;
        k = fn7 - FN7_CPU_REG;
        return rca_cfg_kind_t'(k[2:0]);
    endfunction

endpackage

// File: rtl/rca_cmd_dispatch_fifo.sv
// In-order command queue. Head is read from registered storage, so a
// push into an empty queue becomes visible one cycle later.
module rca_cmd_fifo
    import rca_cmd_dispatch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rca_cmd_t push_cmd,
    input  logic     pop,
    output rca_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    rca_cmd_t       mem [DEPTH];
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           do_push;
    logic           do_pop;

    // The extra top pointer bit tells full apart from empty.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset since the pointers guard them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_cmd;
        end
    end

    // Pointer advance, wrapping naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/rca_cmd_dispatch.sv
// Validates decoded RCA instructions, queues legal ones in order and steers
// the queue head onto either the config-write or the exec port. Keeps a
// per-RCA count of queued config writes so exec can be held off downstream.
module rca_cmd_dispatch
    import rca_cmd_dispatch_pkg::*;
#(
    parameter int NUM_RCAS   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [31:0]         issue_instr,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,
    input  logic [ID_W-1:0]     issue_id,
    output logic                cfg_valid,
    input  logic                cfg_ready,
    output logic [2:0]          cfg_rca_sel,
    output logic [2:0]          cfg_kind,
    output logic [31:0]         cfg_addr,
    output logic [31:0]         cfg_data,
    output logic                exec_valid,
    input  logic                exec_ready,
    output logic [2:0]          exec_rca_sel,
    output logic                exec_use_fb,
    output logic [ID_W-1:0]     exec_id,
    output logic                illegal_valid,
    output logic [ID_W-1:0]     illegal_id,
    output logic [NUM_RCAS-1:0] cfg_pending,
    output logic                empty
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [6:0]      fn7;
    logic [2:0]      fn3;
    logic [6:0]      opcode;
    logic            legal;
    logic            accept;
    logic            push;
    logic            pop;
    logic            cfg_pop;
    logic            fifo_full;
    logic            fifo_empty;
    rca_cmd_t        push_cmd;
    rca_cmd_t        head_cmd;
    logic            illegal_valid_reg;
    logic [ID_W-1:0] illegal_id_reg;
    logic            unused_bits;

    assign fn7    = issue_instr[31:25];
    assign fn3    = issue_instr[14:12];
    assign opcode = issue_instr[6:0];

    // Register-number fields and spare id bits are not needed here.
    assign unused_bits = ^{issue_instr[24:15], issue_instr[11:7], head_cmd.id};

    assign legal  = (opcode == RCA_OPCODE) &&
                    (fn7 <= FN7_IO_INP_MAP) &&
                    ({1'b0, fn3} < 4'(NUM_RCAS));
    assign accept = issue_valid && issue_ready;
    assign push   = accept && legal;

    // Build the queue entry from the incoming instruction.
    always_comb begin
        push_cmd              = '0;
        push_cmd.is_cfg       = (fn7 >= FN7_CPU_REG);
        push_cmd.rca_sel      = fn3;
        push_cmd.kind         = push_cmd.is_cfg ? fn7_to_kind(fn7) : CFG_CPU_REG;
        push_cmd.use_fb       = (fn7 == FN7_USE_FB);
        push_cmd.id[ID_W-1:0] = issue_id;
        push_cmd.addr         = issue_rs1;
        push_cmd.data         = issue_rs2;
    end

    rca_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head steering: exactly one port is valid whenever the queue holds data.
    assign issue_ready  = !fifo_full;
    assign empty        = fifo_empty;
    assign cfg_valid    = !fifo_empty && head_cmd.is_cfg;
    assign exec_valid   = !fifo_empty && !head_cmd.is_cfg;
    assign cfg_rca_sel  = cfg_valid  ? head_cmd.rca_sel    : '0;
    assign cfg_kind     = cfg_valid  ? head_cmd.kind       : '0;
    assign cfg_addr     = cfg_valid  ? head_cmd.addr       : '0;
    assign cfg_data     = cfg_valid  ? head_cmd.data       : '0;
    assign exec_rca_sel = exec_valid ? head_cmd.rca_sel    : '0;
    assign exec_use_fb  = exec_valid ? head_cmd.use_fb     : 1'b0;
    assign exec_id      = exec_valid ? head_cmd.id[ID_W-1:0] : '0;
    assign cfg_pop      = cfg_valid && cfg_ready;
    assign pop          = cfg_pop || (exec_valid && exec_ready);

    // One-cycle report of a rejected instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_valid_reg <= 1'b0;
            illegal_id_reg    <= '0;
        end else begin
            illegal_valid_reg <= accept && !legal;
            if (accept && !legal) illegal_id_reg <= issue_id;
        end
    end

    assign illegal_valid = illegal_valid_reg;
    assign illegal_id    = illegal_id_reg;

    // Per-RCA queued config-write counters.
    for (genvar gi = 0; gi < NUM_RCAS; gi++) begin : g_pend
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt_reg;

        assign inc = push && push_cmd.is_cfg && (fn3 == 3'(gi));
        assign dec = cfg_pop && (head_cmd.rca_sel == 3'(gi));

        // Simultaneous push and handshake to the same RCA cancel out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (inc && !dec) begin
                cnt_reg <= cnt_reg + 1'b1;
            end else if (dec && !inc) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end

        assign cfg_pending[gi] = (cnt_reg != '0);
    end

endmodule
